// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg : micro-state codes, opcode/mode values, ir field bits    |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package cpu_pkg;

  localparam int CPU_STATE_W = 5;
  localparam int CPU_IR_W    = 16;

  typedef enum logic [CPU_STATE_W-1:0] {
    ABDM1 = 5'd0,  ABDM2 = 5'd1,  ABDM3 = 5'd2,  ABDM4 = 5'd3,
    ADRM1 = 5'd4,  BRZZ1 = 5'd5,  BRZZ2 = 5'd6,  BRZZ3 = 5'd7,
    LDRM1 = 5'd8,  LDRM2 = 5'd9,  STRM1 = 5'd10, TEST1 = 5'd11,
    OPRM1 = 5'd12, OPRM2 = 5'd13, LDRR1 = 5'd14, STRR1 = 5'd15,
    POPR1 = 5'd16, POPR2 = 5'd17, PUSH1 = 5'd18, PUSH2 = 5'd19,
    OPRR1 = 5'd20, OPRR2 = 5'd21, DECD1 = 5'd22
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDR  = 4'h1;
  localparam logic [3:0] OP_STR  = 4'h2;
  localparam logic [3:0] OP_OPR  = 4'h3;
  localparam logic [3:0] OP_TST  = 4'h4;
  localparam logic [3:0] OP_BRZ  = 4'h5;
  localparam logic [3:0] OP_PUSH = 4'h6;
  localparam logic [3:0] OP_POP  = 4'h7;

  localparam logic [1:0] MODE_REG = 2'b00;
  localparam logic [1:0] MODE_IND = 2'b01;
  localparam logic [1:0] MODE_IDX = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int ALU_HI  = 11;
  localparam int ALU_LO  = 9;
  localparam int MODE_HI = 7;
  localparam int MODE_LO = 6;
  localparam int RX_HI   = 5;
  localparam int RX_LO   = 3;
  localparam int RY_HI   = 2;
  localparam int RY_LO   = 0;

  // States that wait on the memory handshake when stalling is built in.
  function automatic logic is_mem_state(input state_e s);
    return s inside {ABDM1, ADRM1, BRZZ1, BRZZ3, LDRM1, STRM1, TEST1,
                     OPRM2, LDRR1, STRR1, POPR1, PUSH2, OPRR2};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_decode : opcode/mode/zflag to first micro-state plus illegal  |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module seq_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [1:0] mode_i,
  input  logic       zflag_i,
  output state_e     first_o,
  output logic       illegal_o
);

  always_comb begin
    first_o   = BRZZ3;
    illegal_o = 1'b0;
    if (op_i[3] || mode_i == MODE_RSV) begin
      illegal_o = 1'b1;
    end else begin
      case (op_i)
        OP_NOP: first_o = BRZZ3;
        OP_LDR: begin
          if (mode_i == MODE_REG)      first_o = LDRR1;
          else if (mode_i == MODE_IND) first_o = ADRM1;
          else                         illegal_o = 1'b1;
        end
        OP_STR: begin
          if (mode_i == MODE_REG)      first_o = STRR1;
          else if (mode_i == MODE_IND) first_o = ADRM1;
          else                         first_o = ABDM1;
        end
        OP_OPR: begin
          if (mode_i == MODE_REG)      first_o = OPRR1;
          else if (mode_i == MODE_IND) first_o = ADRM1;
          else                         illegal_o = 1'b1;
        end
        OP_TST: begin
          if (mode_i == MODE_IND)      first_o = ADRM1;
          else                         illegal_o = 1'b1;
        end
        OP_BRZ:  first_o = zflag_i ? BRZZ1 : BRZZ3;
        OP_PUSH: first_o = PUSH1;
        OP_POP:  first_o = POPR1;
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ctrl_sequencer : micro-state sequencer for the datapath FSM       |
// | Optional: SEQ_MEM_STALL_EN adds mem_ready stalling of mem states. |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module ctrl_sequencer
  import cpu_pkg::*;
#(
  parameter int STATE_W = 5,
  parameter int IR_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [IR_W-1:0]    irf,
  input  logic               zflag,
`ifdef SEQ_MEM_STALL_EN
  input  logic               mem_ready,
`endif
  output logic [STATE_W-1:0] state,
  output logic [2:0]         rx,
  output logic [2:0]         ry,
  output logic [2:0]         alu_fn,
  output logic               decode,
  output logic               illegal
);

  state_e            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              illegal_q, illegal_d;
  state_e            dec_first;
  logic              dec_illegal;
  logic              stall;
  logic              unused_ir_bits;

  seq_decode u_decode (
    .op_i      (irf[OP_HI:OP_LO]),
    .mode_i    (irf[MODE_HI:MODE_LO]),
    .zflag_i   (zflag),
    .first_o   (dec_first),
    .illegal_o (dec_illegal)
  );

`ifdef SEQ_MEM_STALL_EN
  assign stall = is_mem_state(state_q) && !mem_ready;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = 1'b0;
    if (!stall) begin
      case (state_q)
        DECD1: begin
          ir_d      = irf;
          state_d   = dec_first;
          illegal_d = dec_illegal;
        end
        ABDM1: state_d = ABDM2;
        ABDM2: state_d = ABDM3;
        ABDM3: state_d = ABDM4;
        ABDM4: state_d = STRM1;
        // The latched copy picks the chain; irf has already moved on.
        ADRM1: begin
          case (ir_q[OP_HI:OP_LO])
            OP_LDR:  state_d = LDRM1;
            OP_STR:  state_d = STRM1;
            OP_OPR:  state_d = OPRM1;
            OP_TST:  state_d = TEST1;
            default: state_d = BRZZ3;
          endcase
        end
        LDRM1: state_d = LDRM2;
        STRM1: state_d = BRZZ3;
        OPRM1: state_d = OPRM2;
        OPRM2: state_d = BRZZ3;
        OPRR1: state_d = OPRR2;
        BRZZ1: state_d = BRZZ2;
        POPR1: state_d = POPR2;
        POPR2: state_d = BRZZ3;
        PUSH1: state_d = PUSH2;
        PUSH2: state_d = BRZZ3;
        LDRR1, STRR1, LDRM2, OPRR2, TEST1, BRZZ2, BRZZ3: state_d = DECD1;
        default: state_d = BRZZ3;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= BRZZ3;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  assign state          = state_q;
  assign rx             = ir_q[RX_HI:RX_LO];
  assign ry             = ir_q[RY_HI:RY_LO];
  assign alu_fn         = ir_q[ALU_HI:ALU_LO];
  assign decode         = (state_q == DECD1);
  assign illegal        = illegal_q;
  assign unused_ir_bits = ^ir_q[8:6];

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ctrl_sequencer : scoreboard bench against a chain-table model  |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_ctrl_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] irf   = 16'h0000;
  logic        zflag = 1'b0;
`ifdef SEQ_MEM_STALL_EN
  logic        mem_ready = 1'b1;
`endif
  logic [4:0]  state;
  logic [2:0]  rx, ry, alu_fn;
  logic        decode, illegal;

  ctrl_sequencer #(.STATE_W(5), .IR_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .irf       (irf),
    .zflag     (zflag),
`ifdef SEQ_MEM_STALL_EN
    .mem_ready (mem_ready),
`endif
    .state     (state),
    .rx        (rx),
    .ry        (ry),
    .alu_fn    (alu_fn),
    .decode    (decode),
    .illegal   (illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] st;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [2:0] fn;
    logic       ill;
    logic       dec;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input int st, input logic [15:0] ir, input logic ill);
    exp_t e;
    e.st  = 5'(st);
    e.rx  = ir[5:3];
    e.ry  = ir[2:0];
    e.fn  = ir[11:9];
    e.ill = ill;
    e.dec = (st == 22);
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.st  = state;
    o.rx  = rx;
    o.ry  = ry;
    o.fn  = alu_fn;
    o.ill = illegal;
    o.dec = decode;
    return o;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got st=%0d rx=%0d ry=%0d fn=%0d ill=%b dec=%b, want st=%0d rx=%0d ry=%0d fn=%0d ill=%b dec=%b",
               name, got.st, got.rx, got.ry, got.fn, got.ill, got.dec,
               want.st, want.rx, want.ry, want.fn, want.ill, want.dec);
    end
  endtask

  // Reference: each legal instruction maps to a fixed list of micro-states.
  task automatic push_chain(input logic [15:0] ir, input logic z);
    logic [3:0] op;
    logic [1:0] md;
    int         ch[$];
    bit         ill;
    op  = ir[15:12];
    md  = ir[7:6];
    ill = 1'b0;
    ch  = {};
    if (op >= 4'd8 || md == 2'd3) ill = 1'b1;
    else case (op)
      4'd0: ch = {7};
      4'd1: if (md == 0) ch = {14}; else if (md == 1) ch = {4, 8, 9}; else ill = 1'b1;
      4'd2: if (md == 0) ch = {15}; else if (md == 1) ch = {4, 10, 7};
            else ch = {0, 1, 2, 3, 10, 7};
      4'd3: if (md == 0) ch = {20, 21}; else if (md == 1) ch = {4, 12, 13, 7}; else ill = 1'b1;
      4'd4: if (md == 1) ch = {4, 11}; else ill = 1'b1;
      4'd5: if (z) ch = {5, 6}; else ch = {7};
      4'd6: ch = {18, 19, 7};
      default: ch = {16, 17, 7};
    endcase
    if (ill) ch = {7};
    ch.push_back(22);
    foreach (ch[i]) exp_q.push_back(mk(ch[i], ir, ill && (i == 0)));
  endtask

  // Runs at a negedge; irf and zflag are scrambled while the chain executes.
  task automatic wait_decode(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (decode === 1'b1) return;
      irf   = 16'($urandom);
      zflag = 1'($urandom);
      @(negedge clock);
    end
    checks++;
    errors++;
    $display("FAIL %s timeout: decode=%b state=%0d, want decode=1 within 20 cycles", tag, decode, state);
    exp_q.delete();
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic z);
    irf   = ir;
    zflag = z;
    push_chain(ir, z);
    @(negedge clock);
    zflag = ~z;
    wait_decode("chain");
  endtask

  initial begin : monitor
    exp_t w;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("seq", observed(), w);
      end
    end
  end

  logic [16:0] dir [0:18] = '{
    {1'b0, 16'h1040}, {1'b0, 16'h106B}, {1'b0, 16'h2080}, {1'b1, 16'h5000},
    {1'b0, 16'h5000}, {1'b0, 16'h90C0}, {1'b0, 16'h3080}, {1'b0, 16'h0000},
    {1'b0, 16'h1E2D}, {1'b0, 16'h3A00}, {1'b0, 16'h2011}, {1'b0, 16'h2040},
    {1'b0, 16'h3C52}, {1'b0, 16'h4040}, {1'b0, 16'h4000}, {1'b1, 16'h6000},
    {1'b0, 16'h7000}, {1'b0, 16'h10C0}, {1'b0, 16'h1080}
  };

  initial begin : stimulus
    logic [3:0]  op;
    logic [15:0] ir;
    @(negedge clock);
    check("reset_state", observed(), mk(7, 16'h0000, 1'b0));
    reset = 1'b0;
    exp_q.push_back(mk(22, 16'h0000, 1'b0));
    @(negedge clock);
    wait_decode("post_reset");

    foreach (dir[i]) run_instr(dir[i][15:0], dir[i][16]);

    for (int n = 0; n < 80; n++) begin
      op = 4'($urandom_range(0, 9));
      if (op >= 4'd8) op = 4'($urandom_range(8, 15));
      ir = {op, 12'($urandom)};
      run_instr(ir, 1'($urandom));
    end

    // Asynchronous reset in the middle of a PUSH chain.
    irf   = 16'h603F;
    zflag = 1'b0;
    @(posedge clock);
    #1;
    check("push1", observed(), mk(18, 16'h603F, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", observed(), mk(7, 16'h0000, 1'b0));
    @(negedge clock);
    check("reset_hold", observed(), mk(7, 16'h0000, 1'b0));
    reset = 1'b0;
    exp_q.push_back(mk(22, 16'h0000, 1'b0));
    @(negedge clock);
    wait_decode("mid_reset");
    run_instr(16'h2080, 1'b0);
    run_instr(16'h3000, 1'b1);

    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
